sad_best_select: RTL and testbench

Motion-estimation SAD stage sitting directly downstream of the reference-row shift chain. Each cycle it consumes one 16-pixel candidate row from the shift stage's wide output, plus the matching current-block row. It accumulates the absolute differences over a full block, then tracks the minimum across all candidates of a search. At the end of the search it reports the best SAD and the candidate index that produced it.

---
 rtl/me_pkg.sv | 31 +++
 rtl/sad_row_tree.sv | 68 ++++++
 rtl/sad_best_select.sv | 211 +++++++++++++++++++++
 tb/tb_sad_best_select.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// me_pkg: shared motion-estimation types and width helpers.
// Used by sad_row_tree and sad_best_select.
package me_pkg;

    localparam int PIXEL_WIDTH = 8;

    // Width that holds the sum of row_pixels*block_rows absolute pixel differences
    function automatic int sad_width(input int pixel_width, input int row_pixels,
                                     input int block_rows);
        return pixel_width + $clog2(row_pixels * block_rows);
    endfunction

    // Width of a counter/index covering 0..count-1 (at least one bit)
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Position flags that travel alongside each row through the pipeline
    typedef struct packed {
        logic first;
        logic last;
        logic search_last;
    } row_tag_t;

endpackage

// File: rtl/sad_row_tree.sv
// sad_row_tree: two-stage row SAD. Stage 1 registers the per-pixel absolute
// differences, stage 2 registers their sum. flush_i drops the row in flight
// in stage 1 so it never reaches the output.
module sad_row_tree #(
    parameter int  PIXEL_WIDTH = me_pkg::PIXEL_WIDTH,
    parameter int  ROW_PIXELS  = 16,
    localparam int ROW_W       = ROW_PIXELS * PIXEL_WIDTH,
    localparam int SUM_W       = me_pkg::sad_width(PIXEL_WIDTH, ROW_PIXELS, 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [ROW_W-1:0] ref_row_i,
    input  logic [ROW_W-1:0] cur_row_i,
    output logic [SUM_W-1:0] sum_o,
    output logic             sum_valid_o
);
    import me_pkg::*;

    logic [PIXEL_WIDTH-1:0] diff_d [ROW_PIXELS];
    logic [PIXEL_WIDTH-1:0] diff_q [ROW_PIXELS];
    logic                   diff_valid_q;
    logic [SUM_W-1:0]       sum_d;
    logic [SUM_W-1:0]       sum_q;
    logic                   sum_valid_q;

    // Absolute difference of each pixel pair (larger minus smaller, never wraps)
    always_comb begin
        for (int p = 0; p < ROW_PIXELS; p++) begin
            diff_d[p] = (ref_row_i[p*PIXEL_WIDTH +: PIXEL_WIDTH] > cur_row_i[p*PIXEL_WIDTH +: PIXEL_WIDTH])
                      ? ref_row_i[p*PIXEL_WIDTH +: PIXEL_WIDTH] - cur_row_i[p*PIXEL_WIDTH +: PIXEL_WIDTH]
                      : cur_row_i[p*PIXEL_WIDTH +: PIXEL_WIDTH] - ref_row_i[p*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end

    // Stage 1: capture the differences of an accepted row
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            diff_valid_q <= 1'b0;
            diff_q       <= '{default: '0};
        end else begin
            diff_valid_q <= valid_i;
            if (valid_i) diff_q <= diff_d;
        end
    end

    // Adder tree over the registered differences, widened so it cannot overflow
    always_comb begin
        sum_d = '0;
        for (int p = 0; p < ROW_PIXELS; p++) sum_d = sum_d + SUM_W'(diff_q[p]);
    end

    // Stage 2: register the row sum; a flush discards the stage-1 row
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_valid_q <= 1'b0;
            sum_q       <= '0;
        end else begin
            sum_valid_q <= diff_valid_q & ~flush_i;
            if (diff_valid_q) sum_q <= sum_d;
        end
    end

    assign sum_o       = sum_q;
    assign sum_valid_o = sum_valid_q;

endmodule

// File: rtl/sad_best_select.sv
// sad_best_select: accumulates row SADs per candidate block and keeps the
// lowest one over a search, reporting it with a done pulse.
// Optional macro SAD_CAND_OUT_EN adds per-candidate SAD outputs.
module sad_best_select #(
    parameter int  PIXEL_WIDTH = me_pkg::PIXEL_WIDTH,
    parameter int  ROW_PIXELS  = 16,
    parameter int  BLOCK_ROWS  = 16,
    parameter int  NUM_CAND    = 49,
    localparam int ROW_W       = ROW_PIXELS * PIXEL_WIDTH,
    localparam int SAD_W       = me_pkg::sad_width(PIXEL_WIDTH, ROW_PIXELS, BLOCK_ROWS),
    localparam int IDX_W       = me_pkg::idx_width(NUM_CAND)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             row_valid_i,
    input  logic [ROW_W-1:0] ref_row_i,
    input  logic [ROW_W-1:0] cur_row_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [SAD_W-1:0] sad_o,
    output logic [IDX_W-1:0] best_idx_o
`ifdef SAD_CAND_OUT_EN
    ,
    output logic [SAD_W-1:0] cand_sad_o,
    output logic             cand_valid_o
`endif
);
    import me_pkg::*;

    localparam int SUM_W     = sad_width(PIXEL_WIDTH, ROW_PIXELS, 1);
    localparam int ROW_CNT_W = idx_width(BLOCK_ROWS);
    localparam logic [ROW_CNT_W-1:0] LAST_ROW  = ROW_CNT_W'(BLOCK_ROWS - 1);
    localparam logic [IDX_W-1:0]     LAST_CAND = IDX_W'(NUM_CAND - 1);

    state_e               state_q, state_d;
    logic                 accept;
    logic [ROW_CNT_W-1:0] row_cnt_q, row_cur;
    logic [IDX_W-1:0]     cand_cnt_q, cand_cur;
    row_tag_t             tag_in, tag_s1_q, tag_s2_q;
    logic [SUM_W-1:0]     row_sum;
    logic                 row_sum_valid;
    logic [SAD_W-1:0]     acc_q;
    logic                 acc_valid_q, acc_last_q, acc_search_last_q;
    logic                 cand_final, new_best;
    logic [SAD_W-1:0]     best_sad_q, sad_q;
    logic [IDX_W-1:0]     best_idx_q, cmp_cand_q, best_idx_out_q;
    logic                 done_q;

    // Row acceptance and the position of the row being accepted; a start
    // restarts the position at row 0 of candidate 0
    always_comb begin
        accept             = row_valid_i & (start_i | (state_q == RUN));
        row_cur            = start_i ? '0 : row_cnt_q;
        cand_cur           = start_i ? '0 : cand_cnt_q;
        tag_in.first       = (row_cur == '0);
        tag_in.last        = (row_cur == LAST_ROW);
        tag_in.search_last = (row_cur == LAST_ROW) & (cand_cur == LAST_CAND);
    end

    // Row/candidate counters advance only on accepted rows
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_cnt_q  <= '0;
            cand_cnt_q <= '0;
        end else begin
            if (start_i) begin
                row_cnt_q  <= '0;
                cand_cnt_q <= '0;
            end
            if (accept) begin
                if (row_cur == LAST_ROW) begin
                    row_cnt_q  <= '0;
                    cand_cnt_q <= cand_cur + 1'b1;
                end else begin
                    row_cnt_q  <= row_cur + 1'b1;
                end
            end
        end
    end

    // Position flags follow the row through the two tree stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_s1_q <= '0;
            tag_s2_q <= '0;
        end else begin
            tag_s1_q <= tag_in;
            tag_s2_q <= tag_s1_q;
        end
    end

    sad_row_tree #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .ROW_PIXELS  (ROW_PIXELS)
    ) u_row_tree (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (start_i),
        .valid_i     (accept),
        .ref_row_i   (ref_row_i),
        .cur_row_i   (cur_row_i),
        .sum_o       (row_sum),
        .sum_valid_o (row_sum_valid)
    );

    // Block accumulator: reloads on a candidate's first row so it never overflows
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q             <= '0;
            acc_valid_q       <= 1'b0;
            acc_last_q        <= 1'b0;
            acc_search_last_q <= 1'b0;
        end else if (start_i) begin
            acc_q             <= '0;
            acc_valid_q       <= 1'b0;
            acc_last_q        <= 1'b0;
            acc_search_last_q <= 1'b0;
        end else begin
            acc_valid_q       <= row_sum_valid;
            acc_last_q        <= tag_s2_q.last;
            acc_search_last_q <= tag_s2_q.search_last;
            if (row_sum_valid) begin
                acc_q <= tag_s2_q.first ? SAD_W'(row_sum) : acc_q + SAD_W'(row_sum);
            end
        end
    end

    assign cand_final = acc_valid_q & acc_last_q;
    assign new_best   = (acc_q < best_sad_q);

    // Best compare: strictly-less keeps the lowest index on ties; the final
    // candidate publishes the result and raises done
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            best_sad_q     <= '1;
            best_idx_q     <= '0;
            cmp_cand_q     <= '0;
            done_q         <= 1'b0;
            sad_q          <= '0;
            best_idx_out_q <= '0;
        end else if (start_i) begin
            best_sad_q <= '1;
            best_idx_q <= '0;
            cmp_cand_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= cand_final & acc_search_last_q;
            if (cand_final) begin
                cmp_cand_q <= cmp_cand_q + 1'b1;
                if (new_best) begin
                    best_sad_q <= acc_q;
                    best_idx_q <= cmp_cand_q;
                end
                if (acc_search_last_q) begin
                    sad_q          <= new_best ? acc_q : best_sad_q;
                    best_idx_out_q <= new_best ? cmp_cand_q : best_idx_q;
                end
            end
        end
    end

`ifdef SAD_CAND_OUT_EN
    logic [SAD_W-1:0] cand_sad_q;
    logic             cand_valid_q;

    // Per-candidate SAD pulse, emitted alongside that candidate's compare
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cand_sad_q   <= '0;
            cand_valid_q <= 1'b0;
        end else if (start_i) begin
            cand_valid_q <= 1'b0;
        end else begin
            cand_valid_q <= cand_final;
            if (cand_final) cand_sad_q <= acc_q;
        end
    end

    assign cand_sad_o   = cand_sad_q;
    assign cand_valid_o = cand_valid_q;
`else
    // Per-candidate outputs are not built in this configuration
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state: start always (re)enters RUN; DRAIN ends with the done pulse
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = (accept && tag_in.search_last) ? DRAIN : RUN;
        end else begin
            case (state_q)
                RUN:     if (accept && tag_in.search_last) state_d = DRAIN;
                DRAIN:   if (done_q) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign sad_o      = sad_q;
    assign best_idx_o = best_idx_out_q;

endmodule

// File: tb/tb_sad_best_select.sv
// tb_sad_best_select: scoreboard bench for sad_best_select with NUM_CAND=4.
// Honours SAD_CAND_OUT_EN to also check the per-candidate outputs.
module tb_sad_best_select;

    localparam int PW   = 8;
    localparam int RP   = 16;
    localparam int BR   = 16;
    localparam int NC   = 4;
    localparam int SW   = 16;
    localparam int IW   = 2;
    localparam int ROWS = NC * BR;

    logic              clk;
    logic              rst_n;
    logic              start_i;
    logic              row_valid_i;
    logic [RP*PW-1:0]  ref_row_i;
    logic [RP*PW-1:0]  cur_row_i;
    logic              busy_o;
    logic              done_o;
    logic [SW-1:0]     sad_o;
    logic [IW-1:0]     best_idx_o;
`ifdef SAD_CAND_OUT_EN
    logic [SW-1:0]     cand_sad_o;
    logic              cand_valid_o;
`endif

    typedef struct {
        int sad;
        int idx;
        int edge_no;
    } result_t;

    result_t exp_q[$];
    int      cand_q[$];
    int      tests_run     = 0;
    int      tests_failed  = 0;
    int      cyc           = 0;
    int      done_seen     = 0;
    int      done_expected = 0;
    bit      check_fall    = 0;

    sad_best_select #(
        .PIXEL_WIDTH (PW),
        .ROW_PIXELS  (RP),
        .BLOCK_ROWS  (BR),
        .NUM_CAND    (NC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start_i),
        .row_valid_i (row_valid_i),
        .ref_row_i   (ref_row_i),
        .cur_row_i   (cur_row_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sad_o       (sad_o),
        .best_idx_o  (best_idx_o)
`ifdef SAD_CAND_OUT_EN
        ,
        .cand_sad_o  (cand_sad_o),
        .cand_valid_o(cand_valid_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time done_o against the last accepted row
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill one row for the given pattern and add its SAD to the running sum
    task automatic makeRow(input int mode, input int cand, inout int cand_sum);
        int c, r;
        for (int p = 0; p < RP; p++) begin
            case (mode)
                0: begin c = $urandom_range(0, 254); r = (cand == 2) ? c : c + 1; end
                1: begin c = $urandom_range(0, 254); r = c + 1; end
                2: begin c = 0; r = 255; end
                default: begin c = $urandom_range(0, 255); r = $urandom_range(0, 255); end
            endcase
            cur_row_i[p*PW +: PW] = c[PW-1:0];
            ref_row_i[p*PW +: PW] = r[PW-1:0];
            cand_sum += (r > c) ? (r - c) : (c - r);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && busy_o === 1'b1; i++) tick();
        checkOutput("wait_idle", {31'd0, busy_o}, 32'd0);
    endtask

    // Drive one search (possibly truncated) and push the expected results
    task automatic applyStimulus(input int mode, input int max_gap, input bit start_with_row,
                                 input int num_rows, input bit push_result, input bit drain_junk);
        int cand_sum  = 0;
        int best_sad  = 32'h7fffffff;
        int best_idx  = 0;
        int last_edge = 0;
        int n         = 0;
        start_i     = 1'b1;
        row_valid_i = start_with_row;
        if (start_with_row) begin
            makeRow(mode, 0, cand_sum);
            n = 1;
        end
        tick();
        start_i = 1'b0;
        while (n < num_rows) begin
            if (n % BR == 0 && n != 0) cand_sum = 0;
            row_valid_i = 1'b0;
            repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) tick();
            makeRow(mode, n / BR, cand_sum);
            row_valid_i = 1'b1;
            if (n == num_rows - 1) last_edge = cyc + 1;
            tick();
            if (n % BR == BR - 1) begin
                if (cand_sum < best_sad) begin
                    best_sad = cand_sum;
                    best_idx = n / BR;
                end
`ifdef SAD_CAND_OUT_EN
                if (push_result || (n / BR) != NC - 1) cand_q.push_back(cand_sum);
`endif
            end
            n++;
        end
        if (start_with_row && BR > 1 && num_rows > 0 && n == 1) cand_sum = cand_sum;
        row_valid_i = 1'b0;
        if (push_result && num_rows == ROWS) begin
            exp_q.push_back('{sad: best_sad, idx: best_idx, edge_no: last_edge + 3});
            done_expected++;
        end
        if (drain_junk) begin
            row_valid_i = 1'b1;
            ref_row_i   = {4{$urandom()}};
            cur_row_i   = {4{$urandom()}};
            repeat (2) tick();
            row_valid_i = 1'b0;
        end
    endtask

    // Scoreboard: pop and compare whenever the DUT reports a result
    always @(negedge clk) begin
        if (rst_n) begin
            if (check_fall) begin
                checkOutput("done_pulse_width", {31'd0, done_o}, 32'd0);
                checkOutput("busy_fall", {31'd0, busy_o}, 32'd0);
                check_fall = 0;
            end
            if (done_o === 1'b1) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    result_t e;
                    e = exp_q.pop_front();
                    checkOutput("sad", {16'd0, sad_o}, e.sad);
                    checkOutput("best_idx", {30'd0, best_idx_o}, e.idx);
                    checkOutput("done_latency", cyc, e.edge_no);
                    checkOutput("busy_at_done", {31'd0, busy_o}, 32'd1);
                    check_fall = 1;
                end
            end
`ifdef SAD_CAND_OUT_EN
            if (cand_valid_o === 1'b1) begin
                if (cand_q.size() == 0) checkOutput("unexpected_cand", 32'd1, 32'd0);
                else checkOutput("cand_sad", {16'd0, cand_sad_o}, cand_q.pop_front());
            end
`endif
        end
    end

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        row_valid_i = 1'b0;
        ref_row_i   = '0;
        cur_row_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_done", {31'd0, done_o}, 32'd0);
        checkOutput("rst_sad", {16'd0, sad_o}, 32'd0);
        checkOutput("rst_idx", {30'd0, best_idx_o}, 32'd0);
`ifdef SAD_CAND_OUT_EN
        checkOutput("rst_cand_sad", {16'd0, cand_sad_o}, 32'd0);
        checkOutput("rst_cand_valid", {31'd0, cand_valid_o}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Rows offered while idle must be ignored
        row_valid_i = 1'b1;
        ref_row_i   = {4{$urandom()}};
        repeat (3) tick();
        row_valid_i = 1'b0;
        checkOutput("idle_busy", {31'd0, busy_o}, 32'd0);

        // Candidate 2 matches exactly, others differ by 1 per pixel
        applyStimulus(0, 0, 1, ROWS, 1, 0);
        waitIdle();
        // All candidates tie at 256: lowest index wins
        applyStimulus(1, 0, 1, ROWS, 1, 0);
        waitIdle();
        // Maximum SAD per candidate without wrap
        applyStimulus(2, 0, 0, ROWS, 1, 0);
        waitIdle();
        // Same as first with row gaps and junk rows during drain
        applyStimulus(0, 3, 0, ROWS, 1, 1);
        waitIdle();
        // Random data, aborted after 20 rows, then a clean search
        applyStimulus(3, 2, 1, 20, 0, 0);
        applyStimulus(3, 1, 0, ROWS, 1, 0);
        waitIdle();

        // Reset while draining: outputs clear at once, no done
        applyStimulus(0, 0, 1, ROWS, 0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("drain_rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("drain_rst_done", {31'd0, done_o}, 32'd0);
        checkOutput("drain_rst_sad", {16'd0, sad_o}, 32'd0);
        checkOutput("drain_rst_idx", {30'd0, best_idx_o}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        waitIdle();
        applyStimulus(1, 2, 1, ROWS, 1, 0);
        waitIdle();

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        repeat (3) tick();
        checkOutput("pending_results", exp_q.size(), 32'd0);
        checkOutput("done_count", done_seen, done_expected);
`ifdef SAD_CAND_OUT_EN
        checkOutput("pending_cands", cand_q.size(), 32'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
